// File: rtl/hazard_pkg.sv
// Shared types and constants for the EX-stage hazard/forwarding controller.
package hazard_pkg;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_NONE = 2'b00;
  localparam fwd_sel_t FWD_MEM  = 2'b01;
  localparam fwd_sel_t FWD_EX   = 2'b10;

  typedef enum logic {
    IDLE,
    STALL
  } state_t;

endpackage

// File: rtl/fwd_src_sel.sv
// Forwarding select for a single source operand; the newer EX/MEM result wins over MEM/WB.
module fwd_src_sel
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] src,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic              exmem_regwrite,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic              memwb_regwrite,
  output fwd_sel_t          sel
);

  logic ex_hit;
  logic mem_hit;

  // Register 0 is hardwired, so it is never a forwarding source.
  assign ex_hit  = exmem_regwrite && (exmem_rd != '0) && (exmem_rd == src);
  assign mem_hit = memwb_regwrite && (memwb_rd != '0) && (memwb_rd == src);

  always_comb begin
    sel = FWD_NONE;
    if (ex_hit) begin
      sel = FWD_EX;
    end else if (mem_hit) begin
      sel = FWD_MEM;
    end
  end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// EX-stage hazard controller: per-operand forwarding, load-use stall FSM,
// branch flush and saturating stall/flush event counters.
module hazard_fwd_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int NUM_SRC  = 2,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_SRC*REG_AW-1:0] ifid_src_i,
  input  logic [NUM_SRC*REG_AW-1:0] idex_src_i,
  input  logic [REG_AW-1:0]         idex_rd_i,
  input  logic                      idex_regwrite_i,
  input  logic                      idex_memread_i,
  input  logic [REG_AW-1:0]         exmem_rd_i,
  input  logic                      exmem_regwrite_i,
  input  logic [REG_AW-1:0]         memwb_rd_i,
  input  logic                      memwb_regwrite_i,
  input  logic                      branch_taken_i,
  output logic [2*NUM_SRC-1:0]      fwd_sel_o,
  output logic                      pc_write_o,
  output logic                      ifid_write_o,
  output logic                      ifid_flush_o,
  output logic                      idex_flush_o,
  output logic                      stall_active_o,
  output logic [CNT_W-1:0]          stall_cnt_o,
  output logic [CNT_W-1:0]          flush_cnt_o
);

  localparam logic [2:0] REM_INIT = 3'(LOAD_LAT - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [2*NUM_SRC-1:0] fwd_raw;
  logic                 hazard;
  state_t               state, state_n;
  logic [2:0]           rem, rem_n;

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    fwd_src_sel #(.REG_AW(REG_AW)) u_sel (
      .src            (idex_src_i[k*REG_AW +: REG_AW]),
      .exmem_rd       (exmem_rd_i),
      .exmem_regwrite (exmem_regwrite_i),
      .memwb_rd       (memwb_rd_i),
      .memwb_regwrite (memwb_regwrite_i),
      .sel            (fwd_raw[2*k +: 2])
    );
  end

  assign fwd_sel_o = rst_i ? '0 : fwd_raw;

  always_comb begin
    hazard = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (idex_rd_i == ifid_src_i[k*REG_AW +: REG_AW]) begin
        hazard = 1'b1;
      end
    end
    hazard = hazard && idex_memread_i && idex_regwrite_i && (idex_rd_i != '0);
  end

  always_comb begin
    state_n        = state;
    rem_n          = rem;
    pc_write_o     = 1'b1;
    ifid_write_o   = 1'b1;
    ifid_flush_o   = 1'b0;
    idex_flush_o   = 1'b0;
    stall_active_o = 1'b0;
    if (rst_i) begin
      state_n = IDLE;
      rem_n   = '0;
    end else if (branch_taken_i) begin
      // A taken branch squashes the hazarding instruction, so any stall is moot.
      ifid_flush_o = 1'b1;
      idex_flush_o = 1'b1;
      state_n      = IDLE;
      rem_n        = '0;
    end else if (state == STALL || hazard) begin
      pc_write_o     = 1'b0;
      ifid_write_o   = 1'b0;
      idex_flush_o   = 1'b1;
      stall_active_o = 1'b1;
      if (state == STALL) begin
        rem_n = rem - 3'd1;
        if (rem == 3'd1) begin
          state_n = IDLE;
        end
      end else if (LOAD_LAT > 1) begin
        state_n = STALL;
        rem_n   = REM_INIT;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      rem         <= '0;
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      state <= state_n;
      rem   <= rem_n;
      if (stall_active_o) begin
        stall_cnt_o <= sat_inc(stall_cnt_o);
      end
      if (branch_taken_i) begin
        flush_cnt_o <= sat_inc(flush_cnt_o);
      end
    end
  end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Self-checking bench: directed test-plan cases plus randomized traffic against a behavioural model.
module tb_hazard_fwd_ctrl;

  localparam int REG_AW   = 5;
  localparam int NUM_SRC  = 2;
  localparam int LOAD_LAT = 3;
  localparam int CNT_W    = 4;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_SRC*REG_AW-1:0] ifid_src;
  logic [NUM_SRC*REG_AW-1:0] idex_src;
  logic [REG_AW-1:0]         idex_rd;
  logic                      idex_regwrite;
  logic                      idex_memread;
  logic [REG_AW-1:0]         exmem_rd;
  logic                      exmem_regwrite;
  logic [REG_AW-1:0]         memwb_rd;
  logic                      memwb_regwrite;
  logic                      branch_taken;
  logic [2*NUM_SRC-1:0]      fwd_sel;
  logic                      pc_write;
  logic                      ifid_write;
  logic                      ifid_flush;
  logic                      idex_flush;
  logic                      stall_active;
  logic [CNT_W-1:0]          stall_cnt;
  logic [CNT_W-1:0]          flush_cnt;

  int vectors    = 0;
  int miscompares = 0;

  // Behavioural model state: stall cycles still owed, event counts.
  int m_left  = 0;
  int m_scnt  = 0;
  int m_fcnt  = 0;
  bit m_valid = 1'b0;

  always #5 clk = ~clk;

  hazard_fwd_ctrl #(
    .REG_AW   (REG_AW),
    .NUM_SRC  (NUM_SRC),
    .LOAD_LAT (LOAD_LAT),
    .CNT_W    (CNT_W)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .ifid_src_i       (ifid_src),
    .idex_src_i       (idex_src),
    .idex_rd_i        (idex_rd),
    .idex_regwrite_i  (idex_regwrite),
    .idex_memread_i   (idex_memread),
    .exmem_rd_i       (exmem_rd),
    .exmem_regwrite_i (exmem_regwrite),
    .memwb_rd_i       (memwb_rd),
    .memwb_regwrite_i (memwb_regwrite),
    .branch_taken_i   (branch_taken),
    .fwd_sel_o        (fwd_sel),
    .pc_write_o       (pc_write),
    .ifid_write_o     (ifid_write),
    .ifid_flush_o     (ifid_flush),
    .idex_flush_o     (idex_flush),
    .stall_active_o   (stall_active),
    .stall_cnt_o      (stall_cnt),
    .flush_cnt_o      (flush_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input logic [REG_AW-1:0] s);
    if (exmem_regwrite && exmem_rd != 0 && exmem_rd == s) return 2'b10;
    if (memwb_regwrite && memwb_rd != 0 && memwb_rd == s) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit ref_hazard();
    if (!(idex_memread && idex_regwrite) || idex_rd == 0) return 1'b0;
    for (int k = 0; k < NUM_SRC; k++)
      if (ifid_src[k*REG_AW +: REG_AW] == idex_rd) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int sat(input int v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1;
  endfunction

  // Model advance at each active edge, using the inputs held through the cycle.
  always @(posedge clk) begin
    if (rst) begin
      m_left  = 0;
      m_scnt  = 0;
      m_fcnt  = 0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      if (branch_taken) begin
        m_left = 0;
        m_fcnt = sat(m_fcnt);
      end else if (m_left > 0) begin
        m_left = m_left - 1;
        m_scnt = sat(m_scnt);
      end else if (ref_hazard()) begin
        m_left = LOAD_LAT - 1;
        m_scnt = sat(m_scnt);
      end
    end
  end

  // Every-cycle comparison on the inactive edge.
  always @(negedge clk) begin : cmp
    logic [2*NUM_SRC-1:0] ef;
    bit stall_exp;
    if (m_valid) begin
      ef = '0;
      if (!rst)
        for (int k = 0; k < NUM_SRC; k++) ef[2*k +: 2] = ref_fwd(idex_src[k*REG_AW +: REG_AW]);
      stall_exp = !rst && !branch_taken && (m_left > 0 || ref_hazard());
      chk("fwd_sel", fwd_sel, ef);
      chk("pc_write", pc_write, !stall_exp);
      chk("ifid_write", ifid_write, !stall_exp);
      chk("ifid_flush", ifid_flush, !rst && branch_taken);
      chk("idex_flush", idex_flush, !rst && (branch_taken || stall_exp));
      chk("stall_active", stall_active, stall_exp);
      chk("stall_cnt", stall_cnt, m_scnt);
      chk("flush_cnt", flush_cnt, m_fcnt);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    ifid_src       = '0;
    idex_src       = '0;
    idex_rd        = '0;
    idex_regwrite  = 1'b0;
    idex_memread   = 1'b0;
    exmem_rd       = '0;
    exmem_regwrite = 1'b0;
    memwb_rd       = '0;
    memwb_regwrite = 1'b0;
    branch_taken   = 1'b0;
  endtask

  task automatic set_load_hazard();
    idex_memread  = 1'b1;
    idex_regwrite = 1'b1;
    idex_rd       = 5'd7;
    ifid_src      = {5'd7, 5'd0};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    clear_in();
    rst = 1'b1;
    exmem_rd       = 5'd3;
    exmem_regwrite = 1'b1;
    idex_src       = {5'd0, 5'd3};
    #3;
    chk("rst_fwd_zero", fwd_sel, 0);
    chk("rst_pc_write", pc_write, 1);
    tick(); #2;
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_flush_cnt", flush_cnt, 0);
    rst = 1'b0;
    clear_in();

    // Two operands forwarded from different stages in the same cycle.
    tick();
    exmem_rd = 5'd3; exmem_regwrite = 1'b1;
    memwb_rd = 5'd4; memwb_regwrite = 1'b1;
    idex_src = {5'd4, 5'd3};
    #2 chk("fwd_split", fwd_sel, 4'b0110);

    tick();
    exmem_rd = 5'd5; memwb_rd = 5'd5;
    idex_src = {5'd0, 5'd5};
    #2 chk("fwd_ex_priority", fwd_sel, 4'b0010);
    tick();
    exmem_rd = 5'd0; memwb_rd = 5'd0;
    idex_src = {5'd0, 5'd0};
    #2 chk("fwd_reg0", fwd_sel, 4'b0000);

    // Load-use stall lasts LOAD_LAT cycles.
    tick();
    clear_in();
    set_load_hazard();
    #2 chk("stall_c0_pc", pc_write, 0);
    chk("stall_c0_active", stall_active, 1);
    tick();
    idex_memread = 1'b0;
    #2 chk("stall_c1_pc", pc_write, 0);
    tick(); #2 chk("stall_c2_pc", pc_write, 0);
    tick(); #2 chk("stall_done_pc", pc_write, 1);
    chk("stall_cnt_3", stall_cnt, 3);

    // Branch beats a simultaneous load-use hazard.
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
    set_load_hazard();
    branch_taken = 1'b1;
    #2 chk("br_ifid_flush", ifid_flush, 1);
    chk("br_idex_flush", idex_flush, 1);
    chk("br_pc_write", pc_write, 1);
    chk("br_no_stall", stall_active, 0);
    tick();
    clear_in();
    #2 chk("br_flush_cnt", flush_cnt, 1);
    chk("br_stall_cnt", stall_cnt, 0);
    chk("br_after_pc", pc_write, 1);

    // Branch in the middle of a stall aborts it.
    tick();
    set_load_hazard();
    tick();
    clear_in();
    branch_taken = 1'b1;
    #2 chk("abort_pc", pc_write, 1);
    chk("abort_active", stall_active, 0);
    tick();
    branch_taken = 1'b0;
    #2 chk("abort_idle", stall_active, 0);

    // Reset in the second stall cycle.
    tick();
    set_load_hazard();
    #2 chk("rst_stall_c0", stall_active, 1);
    tick();
    clear_in();
    rst = 1'b1;
    #2 chk("rst_mid_pc", pc_write, 1);
    chk("rst_mid_active", stall_active, 0);
    chk("rst_mid_idex_flush", idex_flush, 0);
    tick();
    rst = 1'b0;
    #2 chk("rst_after_active", stall_active, 0);
    chk("rst_after_pc", pc_write, 1);
    chk("rst_after_scnt", stall_cnt, 0);
    chk("rst_after_fcnt", flush_cnt, 0);

    // Twenty back-to-back stall cycles saturate a 4-bit counter.
    set_load_hazard();
    repeat (20) tick();
    clear_in();
    #2 chk("stall_cnt_sat", stall_cnt, 15);

    // Randomized traffic, small register space to provoke matches.
    for (int i = 0; i < 3000; i++) begin
      tick();
      rst            = ($urandom_range(63) == 0);
      ifid_src       = {REG_AW'($urandom_range(7)), REG_AW'($urandom_range(7))};
      idex_src       = {REG_AW'($urandom_range(7)), REG_AW'($urandom_range(7))};
      idex_rd        = REG_AW'($urandom_range(7));
      idex_regwrite  = ($urandom_range(3) != 0);
      idex_memread   = ($urandom_range(2) == 0);
      exmem_rd       = REG_AW'($urandom_range(7));
      exmem_regwrite = $urandom_range(1);
      memwb_rd       = REG_AW'($urandom_range(7));
      memwb_regwrite = $urandom_range(1);
      branch_taken   = ($urandom_range(7) == 0);
    end
    tick();
    clear_in();
    rst = 1'b0;
    tick();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hazard_fwd_ctrl.md
# hazard_fwd_ctrl

Parametrised hazard controller for the pipelined CPU's EX stage. It generates per-operand forwarding selects for any number of source operands and detects load-use hazards. It runs a multi-cycle stall state machine sized to the data-memory load latency and issues pipeline flushes on taken branches. Saturating stall and flush event counters support CPI measurement. It sits beside the ID/EX register and drives the PC, IF/ID and ID/EX write and flush controls.

## Interface
Parameters:
- REG_AW, 5, register-address width
- NUM_SRC, 2, source operands per instruction (1..4)
- LOAD_LAT, 1, stall cycles per load-use hazard (1..7)
- CNT_W, 16, width of the performance counters

Ports (one clock; reset is synchronous and active-high):
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- ifid_src_i  in  NUM_SRC*REG_AW  source addresses of the instruction in ID; operand k at bits [k*REG_AW +: REG_AW]
- idex_src_i  in  NUM_SRC*REG_AW  source addresses of the instruction in EX; same packing
- idex_rd_i  in  REG_AW  destination of the instruction in EX
- idex_regwrite_i  in  1  EX instruction writes the register file
- idex_memread_i  in  1  EX instruction is a load
- exmem_rd_i  in  REG_AW  EX/MEM destination
- exmem_regwrite_i  in  1  EX/MEM writes the register file
- memwb_rd_i  in  REG_AW  MEM/WB destination
- memwb_regwrite_i  in  1  MEM/WB writes the register file
- branch_taken_i  in  1  branch resolved taken in EX this cycle
- fwd_sel_o  out  2*NUM_SRC  per-operand select; operand k at [2k +: 2]
- pc_write_o  out  1  PC update enable
- ifid_write_o  out  1  IF/ID update enable
- ifid_flush_o  out  1  zero IF/ID this cycle
- idex_flush_o  out  1  insert a bubble into ID/EX this cycle
- stall_active_o  out  1  a stall cycle is in progress
- stall_cnt_o  out  CNT_W  total stall cycles, saturating
- flush_cnt_o  out  CNT_W  total branch flush events, saturating

## Operation
- Forwarding is combinational and evaluated independently for each operand k:
  - FWD_EX (2'b10) if exmem_regwrite_i and exmem_rd_i≠0 and exmem_rd_i==src_k.
  - Otherwise FWD_MEM (2'b01) if memwb_regwrite_i and memwb_rd_i≠0 and memwb_rd_i==src_k.
  - Otherwise FWD_NONE (2'b00).
  - Two operands may receive different non-zero selects in the same cycle.
- Load-use hazard:
  - Raised when idex_memread_i and idex_regwrite_i and idex_rd_i≠0 and idex_rd_i equals any ifid_src_k.
  - Register 0 never causes a stall or a forward.
- FSM states: IDLE, STALL. The down-counter rem is 3 bits.
  - IDLE, hazard, no branch: stall outputs asserted combinationally. If LOAD_LAT>1, load rem=LOAD_LAT-1 and go to STALL; otherwise stay in IDLE.
  - STALL: stall outputs asserted. rem decrements each cycle; when rem==1, return to IDLE at that edge.
  - Stall outputs: pc_write_o=0, ifid_write_o=0, idex_flush_o=1, stall_active_o=1.
- Branch flush: branch_taken_i asserts ifid_flush_o=1 and idex_flush_o=1 and keeps pc_write_o=1 for that cycle.
  - Branch has priority over the hazard: no stall begins and stall_cnt_o does not increment.
  - A branch in STALL aborts the stall to IDLE.
- Counters:
  - stall_cnt_o increments in every cycle with stall_active_o=1.
  - flush_cnt_o increments in every cycle with branch_taken_i=1.
  - Both hold at all-ones.

## Timing
- Forward selects and first-cycle stall/flush outputs have zero latency, combinational from the inputs.
- A load-use hazard produces exactly LOAD_LAT consecutive stall cycles, starting in the detection cycle.
- While rst_i=1:
  - fwd_sel_o=0, pc_write_o=1, ifid_write_o=1, both flushes 0, stall_active_o=0.
  - At the edge: state←IDLE, rem←0, both counters←0.
- Reset during STALL ends the stall immediately. Outputs return to the non-stall values in the same cycle.
- Counter saturation: a value of all-ones does not wrap.

## Structure
- Package hazard_pkg holds:
  - Constants FWD_NONE, FWD_MEM, FWD_EX.
  - The 2-bit select typedef.
  - The FSM state enum {IDLE, STALL}.
- Sub-module fwd_src_sel computes one operand's select. It is instantiated NUM_SRC times with a generate loop.
- The FSM and counters live in the top module.

## Test plan
- NUM_SRC=2, exmem_rd=3 (regwrite), memwb_rd=4 (regwrite), idex_src={4,3} -> fwd_sel_o = operand0 2'b10, operand1 2'b01 in the same cycle.
- exmem_rd=memwb_rd=5, both regwrite, src0=5 -> operand0 2'b10; with rd=0 on both -> 2'b00.
- LOAD_LAT=3, load idex_rd=7, ifid_src1=7 -> pc_write_o=0 for exactly 3 cycles, then 1; stall_cnt_o=3.
- Load-use hazard and branch_taken_i in the same cycle -> flushes=1, pc_write_o=1, no stall, flush_cnt_o=1, stall_cnt_o=0.
- rst_i=1 in the second cycle of a LOAD_LAT=3 stall -> pc_write_o=1 in that cycle; state IDLE and counters 0 after the edge.
- CNT_W=4, 20 consecutive stall cycles -> stall_cnt_o holds at 15.
